ball_color_ramp: RTL and testbench

BALL_COLOR_RAMP -- requirements
Module: ball_color_ramp

---
 rtl/ball_color_pkg.sv | 20 ++
 rtl/color_sat_step.sv | 41 ++++
 rtl/ball_color_ramp.sv | 121 ++++++++++++
 tb/tb_ball_color_ramp.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_color_pkg.sv
// Shared types and ctrl_word field positions for the ball colour ramp.
package ball_color_pkg;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN,
        SNAP
    } state_t;

    localparam int JUMP_BIT = 31;
    localparam int STEP_LSB = 8;
    localparam int STEP_MSB = 15;

    // A zero step would stall the ramp forever, so it counts as one.
    function automatic logic [7:0] step_fix(input logic [7:0] s);
        return (s == 8'd0) ? 8'd1 : s;
    endfunction

endpackage

// File: rtl/color_sat_step.sv
// One ramp step toward the target, clamped so it never passes the target.
module color_sat_step #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] cur,
    input  logic [CW-1:0] target,
    input  logic [7:0]    step,
    input  logic          up,
    output logic [CW-1:0] stepped,
    output logic          reached
);

    // Wide enough for both the channel and the 8-bit step plus a carry.
    localparam int SW = ((CW > 8) ? CW : 8) + 1;

    logic [SW-1:0] cur_w;
    logic [SW-1:0] tgt_w;
    logic [SW-1:0] stp_w;
    logic [SW-1:0] sum_w;
    logic [SW-1:0] lim_w;
    logic [CW-1:0] dif;

    assign cur_w = SW'(cur);
    assign tgt_w = SW'(target);
    assign stp_w = SW'(step);
    assign sum_w = cur_w + stp_w;
    assign lim_w = tgt_w + stp_w;
    assign dif   = CW'(cur_w - stp_w);

    always_comb begin
        stepped = cur;
        if (up) begin
            stepped = (sum_w >= tgt_w) ? target : CW'(sum_w);
        end else begin
            stepped = (cur_w <= lim_w) ? target : dif;
        end
    end

    assign reached = (stepped == target);

endmodule

// File: rtl/ball_color_ramp.sv
// Ramps one colour channel toward a register-written target, one step
// per TICKS_PER_STEP frame ticks, or snaps straight to it on a jump.
module ball_color_ramp
    import ball_color_pkg::*;
#(
    parameter int CW             = 8,
    parameter int TICKS_PER_STEP = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   ctrl_word,
    input  logic          frame_tick,
    output logic [CW-1:0] color_out,
    output logic          busy,
    output logic          done
);

    localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_STEP - 1);

    state_t        state;
    state_t        state_next;
    logic [31:0]   shadow;
    logic [CW-1:0] target_q;
    logic [CW-1:0] new_target;
    logic [CW-1:0] color_next;
    logic [CW-1:0] sat_next;
    logic [7:0]    step_q;
    logic [7:0]    tick_cnt;
    logic [7:0]    tick_next;
    logic          jump_q;
    logic          change;
    logic          done_next;
    logic          sat_reached;

    assign change     = (ctrl_word != shadow);
    assign new_target = ctrl_word[CW-1:0];
    assign busy       = (state != IDLE);

    color_sat_step #(
        .CW(CW)
    ) u_sat (
        .cur    (color_out),
        .target (target_q),
        .step   (step_q),
        .up     (state == UP),
        .stepped(sat_next),
        .reached(sat_reached)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shadow    <= '0;
            target_q  <= '0;
            step_q    <= '0;
            jump_q    <= 1'b0;
            tick_cnt  <= '0;
            color_out <= '0;
            done      <= 1'b0;
        end else begin
            shadow    <= ctrl_word;
            state     <= state_next;
            tick_cnt  <= tick_next;
            color_out <= color_next;
            done      <= done_next;
            if (change) begin
                target_q <= new_target;
                step_q   <= step_fix(ctrl_word[STEP_MSB:STEP_LSB]);
                jump_q   <= ctrl_word[JUMP_BIT];
            end
        end
    end

    always_comb begin
        state_next = state;
        color_next = color_out;
        tick_next  = tick_cnt;
        done_next  = 1'b0;
        if (change) begin
            // A new word overrides any ramp in flight; a coincident tick is lost.
            tick_next = '0;
            if (ctrl_word[JUMP_BIT]) begin
                state_next = SNAP;
            end else if (new_target > color_out) begin
                state_next = UP;
            end else if (new_target < color_out) begin
                state_next = DOWN;
            end else begin
                state_next = IDLE;
            end
        end else begin
            unique case (state)
                IDLE: begin
                end
                SNAP: begin
                    if (jump_q) begin
                        color_next = target_q;
                    end
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
                UP, DOWN: begin
                    if (frame_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_next  = '0;
                            color_next = sat_next;
                            if (sat_reached) begin
                                done_next  = 1'b1;
                                state_next = IDLE;
                            end
                        end else begin
                            tick_next = tick_cnt + 8'd1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_color_ramp.sv
// Self-checking bench for ball_color_ramp: constant vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_ball_color_ramp;

    localparam int TPS = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ctrl_word;
    logic        frame_tick;
    logic [7:0]  color_out;
    logic        busy;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ball_color_ramp #(
        .CW(8),
        .TICKS_PER_STEP(TPS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ctrl_word (ctrl_word),
        .frame_tick(frame_tick),
        .color_out (color_out),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural model: plain integers and flags.
    int          m_color;
    int          m_tgt;
    int          m_step;
    int          m_cnt;
    logic [31:0] m_prev;
    bit          m_ramp;
    bit          m_snap;
    bit          m_done;

    function automatic void model_reset();
        m_color = 0;
        m_tgt   = 0;
        m_step  = 0;
        m_cnt   = 0;
        m_prev  = '0;
        m_ramp  = 0;
        m_snap  = 0;
        m_done  = 0;
    endfunction

    function automatic void model_edge(logic [31:0] w, bit t);
        m_done = 0;
        if (w != m_prev) begin
            m_tgt  = int'(w[7:0]);
            m_step = (w[15:8] == 8'd0) ? 1 : int'(w[15:8]);
            m_cnt  = 0;
            m_snap = w[31];
            m_ramp = !w[31] && (m_tgt != m_color);
        end else if (m_snap) begin
            m_color = m_tgt;
            m_done  = 1;
            m_snap  = 0;
        end else if (m_ramp && t) begin
            m_cnt++;
            if (m_cnt == TPS) begin
                m_cnt = 0;
                if (m_tgt > m_color)
                    m_color = (m_color + m_step >= m_tgt) ? m_tgt : m_color + m_step;
                else
                    m_color = (m_color - m_step <= m_tgt) ? m_tgt : m_color - m_step;
                if (m_color == m_tgt) begin
                    m_done = 1;
                    m_ramp = 0;
                end
            end
        end
        m_prev = w;
    endfunction

    task automatic check(string name, int ec, bit eb, bit ed);
        logic [7:0] ec8;
        ec8 = ec[7:0];
        vectors++;
        if (color_out !== ec8 || busy !== eb || done !== ed) begin
            miscompares++;
            $display("FAIL %s: got color=%02h busy=%0b done=%0b, want color=%02h busy=%0b done=%0b",
                     name, color_out, busy, done, ec8, eb, ed);
        end
    endtask

    task automatic check_model(string name);
        check(name, m_color, m_ramp || m_snap, m_done);
    endtask

    task automatic check_int(string name, int got, int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(ctrl_word, frame_tick);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        ctrl_word  = '0;
        frame_tick = 1'b0;
        clk_step();
        clk_step();
        check("reset", 0, 0, 0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0] cw;
        bit          tk;
        int          color;
        bit          busy;
        bit          done;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int nd;

        tbl[0]  = '{32'h8000_00AA, 1'b0, 'h00, 1'b1, 1'b0};
        tbl[1]  = '{32'h8000_00AA, 1'b0, 'hAA, 1'b0, 1'b1};
        tbl[2]  = '{32'h8000_00AA, 1'b0, 'hAA, 1'b0, 1'b0};
        tbl[3]  = '{32'h0000_03B0, 1'b1, 'hAA, 1'b1, 1'b0};
        tbl[4]  = '{32'h0000_03B0, 1'b1, 'hAD, 1'b1, 1'b0};
        tbl[5]  = '{32'h0000_03B0, 1'b0, 'hAD, 1'b1, 1'b0};
        tbl[6]  = '{32'h0000_03B0, 1'b1, 'hB0, 1'b0, 1'b1};
        tbl[7]  = '{32'h0000_03B0, 1'b1, 'hB0, 1'b0, 1'b0};
        tbl[8]  = '{32'h0000_00B0, 1'b0, 'hB0, 1'b0, 1'b0};
        tbl[9]  = '{32'h0000_00A0, 1'b0, 'hB0, 1'b1, 1'b0};
        tbl[10] = '{32'h0000_00A0, 1'b1, 'hAF, 1'b1, 1'b0};

        model_reset();
        do_reset();

        foreach (tbl[i]) begin
            ctrl_word  = tbl[i].cw;
            frame_tick = tbl[i].tk;
            clk_step();
            check($sformatf("table_%0d", i), tbl[i].color, tbl[i].busy, tbl[i].done);
        end

        // Long ramp 0 -> 0x80 in steps of 4.
        do_reset();
        ctrl_word = 32'h0000_0480;
        clk_step();
        check("ramp_start", 0, 1, 0);
        nd = 0;
        for (int i = 0; i < 32; i++) begin
            frame_tick = 1'b1;
            clk_step();
            if (done) nd++;
            check($sformatf("ramp_%0d", i), 4 * (i + 1), i < 31, i == 31);
        end
        frame_tick = 1'b0;
        clk_step();
        check("ramp_after", 'h80, 0, 0);
        check_int("ramp_done_count", nd, 1);

        // Saturation at the top.
        ctrl_word = 32'h8000_00FD;
        clk_step();
        clk_step();
        check_model("hold_fd");
        ctrl_word = 32'h0000_05FF;
        clk_step();
        check("top_start", 'hFD, 1, 0);
        frame_tick = 1'b1;
        clk_step();
        frame_tick = 1'b0;
        check("no_wrap", 'hFF, 0, 1);

        // Saturation at the bottom.
        ctrl_word = 32'h8000_0003;
        clk_step();
        clk_step();
        check_model("hold_03");
        ctrl_word = 32'h0000_0500;
        clk_step();
        check("bottom_start", 'h03, 1, 0);
        frame_tick = 1'b1;
        clk_step();
        frame_tick = 1'b0;
        check("no_underflow", 'h00, 0, 1);

        // Retarget mid-ramp: no done for the abandoned target.
        nd = 0;
        ctrl_word = 32'h0000_10F0;
        clk_step();
        check_model("retarget_up");
        frame_tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            if (done) nd++;
            check_model($sformatf("retarget_up_%0d", i));
        end
        ctrl_word = 32'h0000_1010;
        clk_step();
        if (done) nd++;
        check("retarget_switch", 'h30, 1, 0);
        for (int i = 0; i < 2; i++) begin
            clk_step();
            if (done) nd++;
            check_model($sformatf("retarget_down_%0d", i));
        end
        frame_tick = 1'b0;
        check("retarget_end", 'h10, 0, 1);
        check_int("retarget_done_count", nd, 1);

        // Asynchronous reset mid-ramp, then detection after release.
        ctrl_word  = 32'h0000_0180;
        frame_tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            check_model($sformatf("pre_reset_%0d", i));
        end
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 0, 0, 0);
        model_reset();
        clk_step();
        check("reset_hold", 0, 0, 0);
        reset      = 1'b0;
        frame_tick = 1'b0;
        clk_step();
        check("post_reset_detect", 0, 1, 0);

        // Randomized run against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                logic [7:0] stp;
                stp = ($urandom_range(0, 3) == 0) ? 8'd0 :
                      ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 40)) :
                                                    8'($urandom_range(1, 255));
                ctrl_word = {($urandom_range(0, 4) == 0), 15'($urandom), stp,
                             8'($urandom_range(0, 255))};
            end
            frame_tick = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 399) == 0) reset = 1'b1;
            clk_step();
            check_model($sformatf("rand_%0d", n));
            reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
